// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the truth table sweeper
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int N_IN_DEFAULT = 3;
  localparam int NVEC         = 2 ** N_IN_DEFAULT;
  localparam int WAIT_W       = 4;

  function automatic int nvec(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter with zero flag for vector settling
module settle_timer
  import sweep_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Counting stops at zero so a late decrement cannot wrap to the maximum.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweep of a logic block with truth table compare
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN       = N_IN_DEFAULT,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_f,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   result,
  output logic [N_IN:0]        mismatch_cnt
);

  localparam int NV    = nvec(N_IN);
  localparam int IDX_W = N_IN + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYC - 1);

  state_e            state_q;
  logic [NV-1:0]     exp_q;
  logic [IDX_W-1:0]  idx_q;
  logic [N_IN-1:0]   idx_lo;
  logic [N_IN-1:0]   dut_in_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [NV-1:0]     result_q;
  logic [IDX_W-1:0]  mismatch_q;
  logic [IDX_W-1:0]  mismatch_d;
  logic              sample_miss;
  logic              is_last;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_zero;

  assign idx_lo      = idx_q[N_IN-1:0];
  assign is_last     = (idx_q == LAST_IDX);
  assign sample_miss = (state_q == SAMPLE) && (dut_f != exp_q[idx_lo]);
  assign mismatch_d  = mismatch_q + IDX_W'(sample_miss);
  assign timer_load  = ((state_q == IDLE) && start) || ((state_q == SAMPLE) && !is_last);
  assign timer_dec   = (state_q == SETTLE);

  settle_timer #(.W(WAIT_W)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  // done, busy and pass are updated on the edge into DONE so they are valid during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      idx_q      <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      result_q   <= '0;
      mismatch_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q      <= expected;
            idx_q      <= '0;
            dut_in_q   <= '0;
            result_q   <= '0;
            mismatch_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_zero) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          result_q[idx_lo] <= dut_f;
          mismatch_q       <= mismatch_d;
          if (is_last) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            pass_q   <= (mismatch_d == '0);
            dut_in_q <= '0;
            state_q  <= DONE;
          end else begin
            idx_q    <= idx_q + 1'b1;
            dut_in_q <= idx_lo + 1'b1;
            state_q  <= SETTLE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign result       = result_q;
  assign mismatch_cnt = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  localparam logic [7:0] TT = 8'hF8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] exp0 = 8'h00, exp1 = 8'h00;
  logic       dut_f0, dut_f1;
  logic [2:0] dut_in0, dut_in1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] result0, result1;
  logic [3:0] mm0, mm1;
  logic       tog0 = 1'b0, tog1 = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .expected(exp0), .dut_f(dut_f0),
    .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0),
    .result(result0), .mismatch_cnt(mm0)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .dut_f(dut_f1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .result(result1), .mismatch_cnt(mm1)
  );

  // Stand-in logic block F = A | (B & C); its output is inverted on cycles that should be settle-only.
  assign dut_f0 = (dut_in0[2] | (dut_in0[1] & dut_in0[0])) ^ tog0;
  assign dut_f1 = (dut_in1[2] | (dut_in1[1] & dut_in1[0])) ^ tog1;

  function automatic int pop8(input logic [7:0] x);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(x[i]);
    return c;
  endfunction

  // Reference model: per instance, cycles elapsed since start acceptance.
  int         per [2] = '{3, 2};
  logic       m_ok = 1'b0;
  logic       m_act [2];
  int         m_k [2];
  logic [7:0] m_exp [2];
  logic [7:0] m_res_h [2];
  int         m_mm_h [2];
  logic       m_pass [2];

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1;
      for (int u = 0; u < 2; u++) begin
        m_act[u] = 1'b0; m_k[u] = 0; m_exp[u] = 8'h00;
        m_res_h[u] = 8'h00; m_mm_h[u] = 0; m_pass[u] = 1'b0;
      end
    end else if (m_ok) begin
      for (int u = 0; u < 2; u++) begin
        if (m_act[u]) begin
          if (m_k[u] == 8 * per[u] + 1) begin
            m_act[u]   = 1'b0;
            m_res_h[u] = TT;
            m_mm_h[u]  = pop8(TT ^ m_exp[u]);
            m_pass[u]  = (m_mm_h[u] == 0);
          end else begin
            m_k[u] = m_k[u] + 1;
          end
        end else if ((u == 0) ? start0 : start1) begin
          m_act[u] = 1'b1;
          m_k[u]   = 1;
          m_exp[u] = (u == 0) ? exp0 : exp1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int u = 0; u < 2; u++) begin
        logic       e_busy, e_done, e_pass, a_busy, a_done, a_pass, tg;
        logic [2:0] e_in, a_in;
        logic [7:0] e_res, a_res, mask;
        int         e_mm, a_mm, ns, tot;
        tot = 8 * per[u];
        tg  = 1'b0;
        if (m_act[u]) begin
          if (m_k[u] <= tot) begin
            e_busy = 1'b1; e_done = 1'b0;
            e_in   = 3'((m_k[u] - 1) / per[u]);
            ns     = (m_k[u] - 1) / per[u];
            tg     = ((m_k[u] % per[u]) != 0);
          end else begin
            e_busy = 1'b0; e_done = 1'b1; e_in = 3'd0; ns = 8;
          end
          mask  = 8'((32'd1 << ns) - 32'd1);
          e_res = TT & mask;
          e_mm  = pop8((TT ^ m_exp[u]) & mask);
          e_pass = (m_k[u] > tot) ? (e_mm == 0) : m_pass[u];
        end else begin
          e_busy = 1'b0; e_done = 1'b0; e_in = 3'd0;
          e_res = m_res_h[u]; e_mm = m_mm_h[u]; e_pass = m_pass[u];
        end
        if (u == 0) begin
          tog0 = tg;
          a_busy = busy0; a_done = done0; a_pass = pass0; a_in = dut_in0; a_res = result0; a_mm = int'(mm0);
        end else begin
          tog1 = tg;
          a_busy = busy1; a_done = done1; a_pass = pass1; a_in = dut_in1; a_res = result1; a_mm = int'(mm1);
        end
        n_cmp++;
        if ({a_busy, a_done, a_pass, a_in, a_res} !== {e_busy, e_done, e_pass, e_in, e_res} || a_mm != e_mm) begin
          n_fail++;
          $display("FAIL model_u%0d t=%0t: got busy=%b done=%b pass=%b in=%0d res=%h mm=%0d, want busy=%b done=%b pass=%b in=%0d res=%h mm=%0d",
                   u, $time, a_busy, a_done, a_pass, a_in, a_res, a_mm, e_busy, e_done, e_pass, e_in, e_res, e_mm);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic pulse_start(input int u, input logic [7:0] ex);
    if (u == 0) begin exp0 = ex; start0 = 1'b1; end
    else begin exp1 = ex; start1 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int u, input int limit, output int cyc);
    cyc = 1;
    while (!((u == 0) ? done0 : done1) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (!((u == 0) ? done0 : done1)) cyc = -1;
  endtask

  initial begin
    int cyc, nd, first;
    logic pass_at;
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, nd, first;
    logic pass_at;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_u0", {busy0, done0, pass0, dut_in0, result0, mm0}, 32'h0);
    check("reset_u1", {busy1, done1, pass1, dut_in1, result1, mm1}, 32'h0);

    pulse_start(0, 8'hF8);
    wait_done(0, 40, cyc);
    check("match_done_cycle", cyc, 25);
    check("match_result", result0, 8'hF8);
    check("match_pass", pass0, 1'b1);
    check("match_mm", mm0, 4'd0);
    repeat (3) @(negedge clk);

    pulse_start(0, 8'hF9);
    wait_done(0, 40, cyc);
    check("mis_done_cycle", cyc, 25);
    check("mis_result", result0, 8'hF8);
    check("mis_pass", pass0, 1'b0);
    check("mis_mm", mm0, 4'd1);
    repeat (3) @(negedge clk);

    pulse_start(0, 8'hF8);
    nd = 0; first = -1; pass_at = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (done0) begin
        nd++;
        if (first < 0) begin first = c; pass_at = pass0; end
      end
      start0 = (c == 5);
      if (c >= 6) exp0 = 8'h00;
      @(negedge clk);
    end
    start0 = 1'b0;
    check("busy_start_done_count", nd, 1);
    check("busy_start_done_cycle", first, 25);
    check("busy_start_pass", pass_at, 1'b1);

    pulse_start(0, 8'hF8);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {busy0, done0, dut_in0, result0, mm0}, 32'h0);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    check("midrst_no_done", nd, 0);
    pulse_start(0, 8'hF8);
    wait_done(0, 40, cyc);
    check("after_rst_done_cycle", cyc, 25);
    check("after_rst_result", result0, 8'hF8);
    check("after_rst_pass", pass0, 1'b1);
    repeat (3) @(negedge clk);

    pulse_start(1, 8'hF8);
    wait_done(1, 40, cyc);
    check("sc1_done_cycle", cyc, 17);
    check("sc1_result", result1, 8'hF8);
    check("sc1_pass", pass1, 1'b1);
    check("sc1_mm", mm1, 4'd0);
    repeat (3) @(negedge clk);

    pulse_start(1, 8'h07);
    wait_done(1, 40, cyc);
    check("sc1_allbad_done_cycle", cyc, 17);
    check("sc1_allbad_mm", mm1, 4'd8);
    check("sc1_allbad_pass", pass1, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
